// File: rtl/spi_reg_ctrl.sv
// SPI-slave byte stream to register-bus bridge: command byte selects address and
// direction, following bytes write or read consecutive registers.
module spi_reg_ctrl #(
    parameter logic [7:0]  IDLE_BYTE  = 8'hA5,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    input  logic       i_SPI_CS_n,
    output logic [6:0] o_Reg_Addr,
    output logic       o_Reg_WE,
    output logic [7:0] o_Reg_WData,
    output logic       o_Reg_RE,
    input  logic [7:0] i_Reg_RData,
    input  logic       i_Reg_RValid,
    output logic       o_Busy,
    output logic       o_Err
);

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [DW-1:0] TIMEOUT_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        RD_REQ,
        RD_WAIT,
        RD_SHIFT
    } state_t;

    state_t state, state_d;

    logic          cs_s1, cs_s2, cs_prev;
    logic [1:0]    sync_vld;
    logic          armed;
    logic          cs_fall_c, cs_end_c;
    logic [CW-1:0] cnt, cnt_d;

    logic          tx_dv_d, we_d, re_d, err_d, busy_d;
    logic [DW-1:0] tx_byte_d, wdata_d;
    logic [AW-1:0] addr_d;

    // CS synchronizer; armed only once a real high level has been seen after
    // reset, so CS held low across reset release never starts a transaction.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            cs_prev  <= 1'b1;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            cs_s1    <= i_SPI_CS_n;
            cs_s2    <= cs_s1;
            cs_prev  <= cs_s2;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && cs_s2) begin
                armed <= 1'b1;
            end
        end
    end

    assign cs_fall_c = armed & cs_prev & ~cs_s2;
    assign cs_end_c  = ~cs_prev & cs_s2;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= IDLE;
            cnt         <= '0;
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= '0;
            o_Reg_Addr  <= '0;
            o_Reg_WE    <= 1'b0;
            o_Reg_WData <= '0;
            o_Reg_RE    <= 1'b0;
            o_Busy      <= 1'b0;
            o_Err       <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            o_TX_DV     <= tx_dv_d;
            o_TX_Byte   <= tx_byte_d;
            o_Reg_Addr  <= addr_d;
            o_Reg_WE    <= we_d;
            o_Reg_WData <= wdata_d;
            o_Reg_RE    <= re_d;
            o_Busy      <= busy_d;
            o_Err       <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        tx_dv_d   = 1'b0;
        tx_byte_d = o_TX_Byte;
        addr_d    = o_Reg_Addr;
        we_d      = 1'b0;
        wdata_d   = o_Reg_WData;
        re_d      = 1'b0;
        err_d     = o_Err;

        // Post-increment after the write strobe has used the current address.
        if (o_Reg_WE) begin
            addr_d = o_Reg_Addr + AW'(1);
        end

        case (state)
            IDLE: begin
                if (cs_fall_c) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = IDLE_BYTE;
                    err_d     = 1'b0;
                    state_d   = CMD;
                end
            end
            CMD: begin
                if (i_RX_DV) begin
                    addr_d  = i_RX_Byte[AW-1:0];
                    state_d = i_RX_Byte[DW-1] ? RD_REQ : WRITE;
                end
            end
            WRITE: begin
                if (i_RX_DV) begin
                    wdata_d = i_RX_Byte;
                    we_d    = 1'b1;
                end
            end
            RD_REQ: begin
                re_d    = 1'b1;
                cnt_d   = '0;
                state_d = RD_WAIT;
                if (i_RX_DV) begin
                    err_d = 1'b1;
                end
            end
            RD_WAIT: begin
                if (i_RX_DV) begin
                    err_d = 1'b1;
                end
                if (i_Reg_RValid) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = i_Reg_RData;
                    state_d   = RD_SHIFT;
                end else if (cnt == CW'(RD_TIMEOUT - 1)) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = TIMEOUT_BYTE;
                    err_d     = 1'b1;
                    state_d   = RD_SHIFT;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RD_SHIFT: begin
                if (i_RX_DV) begin
                    addr_d  = o_Reg_Addr + AW'(1);
                    state_d = RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // CS end aborts: byte already received still lands, but no new TX/RE.
        if (cs_end_c && (state != IDLE)) begin
            state_d   = IDLE;
            tx_dv_d   = 1'b0;
            tx_byte_d = o_TX_Byte;
            re_d      = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: table of write/read bursts plus hand-written
// timeout, abort, CS-end and reset sequences.
module tb_spi_reg_ctrl;

    localparam int unsigned GAP = 30;

    logic       clk = 1'b0;
    logic       rst, cs_n, rx_dv, tx_dv, reg_we, reg_re, reg_rvalid, busy, err;
    logic [7:0] rx_byte, tx_byte, reg_wdata, reg_rdata;
    logic [6:0] reg_addr;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_reg_ctrl #(.IDLE_BYTE(8'hA5), .RD_TIMEOUT(15)) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .i_SPI_CS_n  (cs_n),
        .o_Reg_Addr  (reg_addr),
        .o_Reg_WE    (reg_we),
        .o_Reg_WData (reg_wdata),
        .o_Reg_RE    (reg_re),
        .i_Reg_RData (reg_rdata),
        .i_Reg_RValid(reg_rvalid),
        .o_Busy      (busy),
        .o_Err       (err)
    );

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    // Write: a0/d0, a1/d1 expected WE pairs. Read: a0..a2 expected RE
    // addresses, d0..d2 expected TX bytes after the 0xA5 idle byte.
    typedef struct {
        logic [7:0] cmd, b1, b2;
        logic [7:0] a0, a1, a2;
        logic [7:0] d0, d1, d2;
    } vec_t;

    ev_t  we_q[$], re_q[$], tx_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   fails  = 0;
    int   last_dv_cyc = 0;
    bit   resp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_byte     = b;
        rx_dv       = 1'b1;
        last_dv_cyc = cyc;
        tick();
        rx_dv = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic clear_q();
        we_q.delete();
        re_q.delete();
        tx_q.delete();
    endtask

    // Register model: answers each RE three cycles later with addr + 0x40.
    task automatic responder();
        logic [6:0] a;
        forever begin
            tick();
            if (resp_en && reg_re) begin
                a = reg_addr;
                repeat (3) @(posedge clk);
                #1;
                reg_rdata  = {1'b0, a} + 8'h40;
                reg_rvalid = 1'b1;
                tick();
                reg_rvalid = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        int n;
        forever begin
            @(negedge clk);
            n = int'(reg_we) + int'(reg_re) + int'(tx_dv);
            if (n != 0) chk("strobe_onehot", n, 1);
            if (reg_we) we_q.push_back('{cyc, {1'b0, reg_addr}, reg_wdata});
            if (reg_re) re_q.push_back('{cyc, {1'b0, reg_addr}, 8'h00});
            if (tx_dv)  tx_q.push_back('{cyc, 8'h00, tx_byte});
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({tx_dv, tx_byte, reg_addr, reg_we, reg_wdata, reg_re, busy, err});
    endfunction

    initial begin
        vecs[0] = '{8'h05, 8'h11, 8'h22, 8'h05, 8'h06, 8'h00, 8'h11, 8'h22, 8'h00};
        vecs[1] = '{8'h7F, 8'hAA, 8'h55, 8'h7F, 8'h00, 8'h00, 8'hAA, 8'h55, 8'h00};
        vecs[2] = '{8'h30, 8'h00, 8'hFF, 8'h30, 8'h31, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'hFE, 8'hFF, 8'h00, 8'h7E, 8'h7F, 8'h00, 8'hBE, 8'hBF, 8'h40};
        vecs[4] = '{8'h80, 8'h12, 8'h34, 8'h00, 8'h01, 8'h02, 8'h40, 8'h41, 8'h42};
        vecs[5] = '{8'h93, 8'h00, 8'h00, 8'h13, 8'h14, 8'h15, 8'h53, 8'h54, 8'h55};

        rst = 1'b1; cs_n = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
        reg_rdata = 8'h00; reg_rvalid = 1'b0;
        fork
            responder();
            monitor();
        join_none

        repeat (3) tick();
        chk("reset_outs", all_outs(), 32'h0);
        rst = 1'b0;
        repeat (5) tick();

        // Table-driven bursts
        resp_en = 1'b1;
        foreach (vecs[i]) begin
            clear_q();
            cs_n = 1'b0;
            repeat (6) tick();
            chk("busy_in_txn", busy, 1);
            send(vecs[i].cmd, GAP);
            send(vecs[i].b1, GAP);
            send(vecs[i].b2, GAP);
            cs_n = 1'b1;
            repeat (8) tick();
            chk("busy_after", busy, 0);
            chk("err_after", err, 0);
            if (!vecs[i].cmd[7]) begin
                chk("w_we_cnt", we_q.size(), 2);
                chk("w_re_cnt", re_q.size(), 0);
                chk("w_tx_cnt", tx_q.size(), 1);
                if (we_q.size() == 2) begin
                    chk("w_a0", we_q[0].a, vecs[i].a0);
                    chk("w_d0", we_q[0].d, vecs[i].d0);
                    chk("w_a1", we_q[1].a, vecs[i].a1);
                    chk("w_d1", we_q[1].d, vecs[i].d1);
                end
                if (tx_q.size() == 1) chk("w_tx_idle", tx_q[0].d, 8'hA5);
            end else begin
                chk("r_we_cnt", we_q.size(), 0);
                chk("r_re_cnt", re_q.size(), 3);
                chk("r_tx_cnt", tx_q.size(), 4);
                if (re_q.size() == 3 && tx_q.size() == 4) begin
                    chk("r_a0", re_q[0].a, vecs[i].a0);
                    chk("r_a1", re_q[1].a, vecs[i].a1);
                    chk("r_a2", re_q[2].a, vecs[i].a2);
                    chk("r_tx_idle", tx_q[0].d, 8'hA5);
                    chk("r_d0", tx_q[1].d, vecs[i].d0);
                    chk("r_d1", tx_q[2].d, vecs[i].d1);
                    chk("r_d2", tx_q[3].d, vecs[i].d2);
                    chk("r_lat_re", re_q[2].cyc - last_dv_cyc, 2);
                    chk("r_lat_tx", tx_q[1].cyc - re_q[0].cyc, 4);
                end
            end
            repeat (4) tick();
        end

        // Read timeout at 0x10, sticky error cleared by next CS fall
        resp_en = 1'b0;
        clear_q();
        cs_n = 1'b0;
        repeat (6) tick();
        send(8'h90, GAP);
        chk("to_re_cnt", re_q.size(), 1);
        chk("to_tx_cnt", tx_q.size(), 2);
        if (re_q.size() == 1 && tx_q.size() == 2) begin
            chk("to_addr", re_q[0].a, 8'h10);
            chk("to_byte", tx_q[1].d, 8'hEE);
            chk("to_cycles", tx_q[1].cyc - re_q[0].cyc, 15);
        end
        chk("to_err", err, 1);
        cs_n = 1'b1;
        repeat (6) tick();
        chk("to_err_sticky", err, 1);
        cs_n = 1'b0;
        repeat (6) tick();
        chk("to_err_clr", err, 0);
        cs_n = 1'b1;
        repeat (6) tick();

        // Master too fast: RX byte during RD_WAIT flags error, then CS abort
        clear_q();
        cs_n = 1'b0;
        repeat (6) tick();
        send(8'h85, 2);
        send(8'h00, 2);
        chk("fast_err", err, 1);
        chk("fast_busy", busy, 1);
        cs_n = 1'b1;
        repeat (20) tick();
        chk("fast_re_cnt", re_q.size(), 1);
        chk("fast_tx_cnt", tx_q.size(), 1);
        chk("fast_idle", busy, 0);

        // Abort in RD_WAIT: RValid coincident with synchronized CS end
        clear_q();
        cs_n = 1'b0;
        repeat (6) tick();
        send(8'h90, 2);
        cs_n = 1'b1;
        tick();
        tick();
        reg_rdata  = 8'h77;
        reg_rvalid = 1'b1;
        tick();
        reg_rvalid = 1'b0;
        chk("abort_busy", busy, 0);
        repeat (3) tick();
        reg_rvalid = 1'b1;
        tick();
        reg_rvalid = 1'b0;
        repeat (4) tick();
        chk("abort_tx_cnt", tx_q.size(), 1);
        chk("abort_re_cnt", re_q.size(), 1);
        chk("abort_idle", busy, 0);

        // RX byte coincident with synchronized CS end in WRITE
        clear_q();
        cs_n = 1'b0;
        repeat (6) tick();
        send(8'h02, GAP);
        cs_n = 1'b1;
        tick();
        tick();
        rx_byte = 8'h33;
        rx_dv   = 1'b1;
        tick();
        rx_dv = 1'b0;
        repeat (6) tick();
        chk("edge_we_cnt", we_q.size(), 1);
        if (we_q.size() == 1) begin
            chk("edge_addr", we_q[0].a, 8'h02);
            chk("edge_data", we_q[0].d, 8'h33);
        end
        chk("edge_idle", busy, 0);

        // Reset mid-write with CS held low
        clear_q();
        cs_n = 1'b0;
        repeat (6) tick();
        send(8'h40, GAP);
        send(8'h99, GAP);
        chk("rst_pre_we", we_q.size(), 1);
        rx_byte = 8'h12;
        rx_dv   = 1'b1;
        rst     = 1'b1;
        tick();
        rx_dv = 1'b0;
        rst   = 1'b0;
        chk("rst_outs", all_outs(), 32'h0);
        repeat (20) tick();
        chk("rst_no_start", busy, 0);
        chk("rst_we_cnt", we_q.size(), 1);
        chk("rst_tx_cnt", tx_q.size(), 1);
        cs_n = 1'b1;
        repeat (6) tick();
        cs_n = 1'b0;
        repeat (6) tick();
        chk("rst_restart", busy, 1);
        chk("rst_tx_cnt2", tx_q.size(), 2);
        if (tx_q.size() == 2) chk("rst_tx_idle", tx_q[1].d, 8'hA5);
        cs_n = 1'b1;
        repeat (6) tick();
        chk("rst_end_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter IDLE_BYTE, default 8'hA5, the byte loaded to the SPI slave TX path at transaction start and shifted out during the command byte.
REQ-002 SHALL have parameter RD_TIMEOUT, default 15, the maximum i_Clk cycles to wait for i_Reg_RValid after o_Reg_RE.
REQ-003 SHALL have port i_Clk, input, 1 bit: the only clock for all logic.
REQ-004 SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_RX_DV, input, 1 bit: SPI slave received-byte strobe, one cycle wide.
REQ-006 SHALL have port i_RX_Byte, input, 8 bits: SPI slave received byte, valid while i_RX_DV is high.
REQ-007 SHALL have port o_TX_DV, output, 1 bit: one-cycle pulse that registers o_TX_Byte into the SPI slave.
REQ-008 SHALL have port o_TX_Byte, output, 8 bits: next byte for MISO.
REQ-009 SHALL have port i_SPI_CS_n, input, 1 bit: raw asynchronous chip select, active-low.
REQ-010 SHALL have port o_Reg_Addr, output, 7 bits: register address.
REQ-011 SHALL have port o_Reg_WE, output, 1 bit: one-cycle write strobe.
REQ-012 SHALL have port o_Reg_WData, output, 8 bits: write data.
REQ-013 SHALL have port o_Reg_RE, output, 1 bit: one-cycle read request.
REQ-014 SHALL have port i_Reg_RData, input, 8 bits: read data, valid while i_Reg_RValid is high.
REQ-015 SHALL have port i_Reg_RValid, input, 1 bit: read data valid strobe.
REQ-016 SHALL have port o_Busy, output, 1 bit: high when the state is not IDLE.
REQ-017 SHALL have port o_Err, output, 1 bit: sticky read-timeout flag.

Function
REQ-018 SHALL pass i_SPI_CS_n through a 2-flop synchronizer; "CS active" means the synchronized value is 0, and "CS end" means a synchronized 0->1 edge.
REQ-019 SHALL implement the states IDLE, CMD, WRITE, RD_REQ, RD_WAIT and RD_SHIFT.
REQ-020 IDLE: on a synchronized 1->0 CS edge, SHALL pulse o_TX_DV with o_TX_Byte=IDLE_BYTE, clear o_Err, and go to CMD.
REQ-021 CMD: on i_RX_DV, SHALL load o_Reg_Addr with i_RX_Byte[6:0]; if i_RX_Byte[7]=0 it goes to WRITE, and if i_RX_Byte[7]=1 it goes to RD_REQ.
REQ-022 WRITE: on each i_RX_DV, SHALL drive o_Reg_WData=i_RX_Byte and pulse o_Reg_WE in the following cycle using the current o_Reg_Addr, then increment o_Reg_Addr.
REQ-023 RD_REQ: SHALL pulse o_Reg_RE for one cycle and go to RD_WAIT.
REQ-024 RD_WAIT: on i_Reg_RValid, SHALL pulse o_TX_DV with o_TX_Byte=i_Reg_RData and go to RD_SHIFT.
REQ-025 RD_WAIT: if RD_TIMEOUT cycles elapse after o_Reg_RE without i_Reg_RValid, SHALL pulse o_TX_DV with o_TX_Byte=8'hEE, set o_Err, and go to RD_SHIFT.
REQ-026 RD_SHIFT: on i_RX_DV (the byte clocked out, MOSI ignored), SHALL increment o_Reg_Addr and go to RD_REQ.
REQ-027 Address increment SHALL be modulo 128, so 7'h7F wraps to 7'h00.
REQ-028 Read latency from i_RX_DV (command) to o_Reg_RE SHALL be 2 cycles; from i_Reg_RValid to o_TX_DV it SHALL be 1 cycle.
REQ-029 Master gap: the SPI master SHALL leave at least (RD_TIMEOUT+4) i_Clk cycles after each read byte before the next byte; this is a system-level rule and is not checked by the block.
REQ-030 CS end in any non-IDLE state SHALL force IDLE on the next cycle; no further o_Reg_RE, o_Reg_WE or o_TX_DV is issued.
REQ-031 A write strobe already scheduled for that cycle under REQ-022 SHALL still complete.
REQ-032 i_RX_DV coincident with CS end SHALL be processed first (a WRITE data byte is still written), then the state goes to IDLE.
REQ-033 i_RX_DV in RD_REQ or RD_WAIT (master too fast) SHALL be ignored and SHALL set o_Err.
REQ-034 i_Reg_RValid outside RD_WAIT SHALL be ignored.
REQ-035 i_RX_DV while in IDLE SHALL be ignored.
REQ-036 o_Reg_WE, o_Reg_RE and o_TX_DV SHALL never be high in the same cycle.

Reset
REQ-037 While i_Rst=1 at a rising edge of i_Clk, the block SHALL enter IDLE; synchronizer flops are set to 1; o_TX_DV, o_Reg_WE, o_Reg_RE, o_Busy and o_Err are 0; o_TX_Byte, o_Reg_Addr and o_Reg_WData are 0; the timeout counter is 0.
REQ-038 Reset asserted mid-transaction SHALL abort it with no further strobes.
REQ-039 After reset, a transaction SHALL start only on a new CS 1->0 edge; CS already low at reset release SHALL NOT start one.

Verification
REQ-040 Write burst: CS low, RX bytes 0x05, 0x11, 0x22 -> o_TX_DV with 0xA5; WE at addr 0x05 with data 0x11, then addr 0x06 with data 0x22; no o_Reg_RE.
REQ-041 Read burst: RX 0x80|0x7E, then 2 dummy bytes, with RData=addr+0x40 after 3 cycles -> o_TX_Byte 0xBE, 0xBF, then RE at addr 0x00 (wrap).
REQ-042 Timeout: read command at addr 0x10 with RValid never asserted -> after 15 cycles, o_TX_Byte=0xEE and o_Err=1; o_Err clears at the next CS falling edge.
REQ-043 Abort: CS rises while in RD_WAIT, then RValid arrives -> IDLE, no o_TX_DV, o_Busy=0 within 4 cycles of the CS rise.
REQ-044 Edge: i_RX_DV (0x33) coincident with synchronized CS end in WRITE at addr 0x02 -> one WE with addr 0x02 and data 0x33, then IDLE.
REQ-045 Reset: i_Rst pulsed mid-write with CS held low -> all outputs zero, and no transaction until CS toggles high then low.
